// File: rtl/uart_core_if.sv
// User-side bundle of the UART core: TX byte handshake plus RX frame results.
// master = user logic, slave = uart_core.
interface uart_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_core.sv
// Single-clock full-duplex UART. Bit cells are timed by counters on clk; RX samples each
// cell in its middle after a 2-FF synchroniser and reports parity and framing errors.
module uart_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  uart_core_if.slave  bus,
  output logic        txd,
  input  logic        rxd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CELL_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Odd parity makes the total count of ones (data + parity) odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    logic p_s;
    p_s = ^d;
    if (PARITY == 1) begin
      parity_bit = ~p_s;
    end else begin
      parity_bit = p_s;
    end
  endfunction

  tx_state_t            tx_state_r;
  logic [CW-1:0]        tx_cnt_r;
  logic [BW-1:0]        tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_par_r;
  logic                 txd_r;
  logic                 tx_ready_r;
  logic                 tx_busy_r;

  rx_state_t            rx_state_r;
  logic [CW-1:0]        rx_cnt_r;
  logic [BW-1:0]        rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic                 rx_par_r;
  logic                 rx_wait_high_r;
  logic                 sync1_r;
  logic                 sync2_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 rx_perr_r;
  logic                 rx_ferr_r;

  assign txd               = txd_r;
  assign bus.tx_ready      = tx_ready_r;
  assign bus.tx_busy       = tx_busy_r;
  assign bus.rx_data       = rx_data_r;
  assign bus.rx_valid      = rx_valid_r;
  assign bus.rx_parity_err = rx_perr_r;
  assign bus.rx_frame_err  = rx_ferr_r;

  // TX state machine: shifts the latched word out LSB first, one cell per CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CW'(0);
      tx_bit_r   <= BW'(0);
      tx_shift_r <= {DATA_BITS{1'b0}};
      tx_par_r   <= 1'b0;
      txd_r      <= 1'b1;
      tx_ready_r <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (bus.tx_valid && tx_ready_r) begin
            tx_shift_r <= bus.tx_data;
            tx_par_r   <= parity_bit(bus.tx_data);
            tx_cnt_r   <= CW'(0);
            txd_r      <= 1'b0;
            tx_ready_r <= 1'b0;
            tx_busy_r  <= 1'b1;
            tx_state_r <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_r == CELL_LAST) begin
            tx_cnt_r   <= CW'(0);
            tx_bit_r   <= BW'(0);
            txd_r      <= tx_shift_r[0];
            tx_state_r <= TX_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_r == CELL_LAST) begin
            tx_cnt_r <= CW'(0);
            if (tx_bit_r == BIT_LAST) begin
              tx_bit_r <= BW'(0);
              if (PARITY != 0) begin
                txd_r      <= tx_par_r;
                tx_state_r <= TX_PARITY;
              end else begin
                txd_r      <= 1'b1;
                tx_state_r <= TX_STOP;
              end
            end else begin
              tx_bit_r   <= tx_bit_r + BW'(1);
              txd_r      <= tx_shift_r[1];
              tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CW'(1);
          end
        end
        TX_PARITY: begin
          if (tx_cnt_r == CELL_LAST) begin
            tx_cnt_r   <= CW'(0);
            tx_bit_r   <= BW'(0);
            txd_r      <= 1'b1;
            tx_state_r <= TX_STOP;
          end else begin
            tx_cnt_r <= tx_cnt_r + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_r == CELL_LAST) begin
            tx_cnt_r <= CW'(0);
            if (tx_bit_r == STOP_LAST) begin
              tx_bit_r   <= BW'(0);
              tx_ready_r <= 1'b1;
              tx_busy_r  <= 1'b0;
              tx_state_r <= TX_IDLE;
            end else begin
              tx_bit_r <= tx_bit_r + BW'(1);
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CW'(1);
          end
        end
        default: begin
          txd_r      <= 1'b1;
          tx_ready_r <= 1'b1;
          tx_busy_r  <= 1'b0;
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

  // Two-stage synchroniser for the asynchronous rxd pin, preset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
    end
  end

  // RX state machine: validates the start bit at half cell, then samples every cell middle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r     <= RX_IDLE;
      rx_cnt_r       <= CW'(0);
      rx_bit_r       <= BW'(0);
      rx_shift_r     <= {DATA_BITS{1'b0}};
      rx_par_r       <= 1'b0;
      rx_wait_high_r <= 1'b0;
      rx_data_r      <= {DATA_BITS{1'b0}};
      rx_valid_r     <= 1'b0;
      rx_perr_r      <= 1'b0;
      rx_ferr_r      <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (sync2_r) begin
            rx_wait_high_r <= 1'b0;
          end else if (!rx_wait_high_r) begin
            rx_cnt_r   <= CW'(0);
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_r == CELL_HALF) begin
            rx_cnt_r <= CW'(0);
            rx_bit_r <= BW'(0);
            if (!sync2_r) begin
              rx_state_r <= RX_DATA;
            end else begin
              rx_state_r <= RX_IDLE;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == CELL_LAST) begin
            rx_cnt_r   <= CW'(0);
            rx_shift_r <= {sync2_r, rx_shift_r[DATA_BITS-1:1]};
            if (rx_bit_r == BIT_LAST) begin
              rx_bit_r <= BW'(0);
              if (PARITY != 0) begin
                rx_state_r <= RX_PARITY;
              end else begin
                rx_state_r <= RX_STOP;
              end
            end else begin
              rx_bit_r <= rx_bit_r + BW'(1);
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_PARITY: begin
          if (rx_cnt_r == CELL_LAST) begin
            rx_cnt_r   <= CW'(0);
            rx_par_r   <= sync2_r;
            rx_state_r <= RX_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == CELL_LAST) begin
            rx_cnt_r       <= CW'(0);
            rx_data_r      <= rx_shift_r;
            rx_valid_r     <= 1'b1;
            rx_perr_r      <= (PARITY != 0) && (rx_par_r != parity_bit(rx_shift_r));
            rx_ferr_r      <= ~sync2_r;
            rx_wait_high_r <= ~sync2_r;
            rx_state_r     <= RX_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        default: begin
          rx_cnt_r   <= CW'(0);
          rx_state_r <= RX_IDLE;
        end
      endcase
    end
  end
endmodule
